// File: rtl/fb_pkg.sv
// Shared pixel-format, write-mask, dither and state definitions for the frame-buffer writer and display block.
package fb_pkg;

    localparam int RGB888_R_LSB = 16;
    localparam int RGB888_G_LSB = 8;
    localparam int RGB888_B_LSB = 0;
    localparam int RGB888_CH_W  = 8;

    localparam int RGB565_R_LSB = 0;
    localparam int RGB565_R_W   = 5;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_G_W   = 6;
    localparam int RGB565_B_LSB = 11;
    localparam int RGB565_B_W   = 5;

    localparam logic [3:0] WR_MASK_RGB = 4'b0111;

    // 2x2 ordered-dither thresholds, two bits per entry, indexed by {y[0], x[0]}.
    localparam logic [7:0] DITHER_TABLE = {2'd1, 2'd3, 2'd2, 2'd0};

    function automatic logic [1:0] dither_t(input logic [1:0] idx);
        return DITHER_TABLE[{idx, 1'b0} +: 2];
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } fb_state_e;

endpackage

// File: rtl/rgb888_to_565.sv
// Combinational RGB888 -> packed {B,G,R} conversion; FB_DITHER_EN adds a saturating 2x2 ordered dither.
module rgb888_to_565
    import fb_pkg::*;
#(
    parameter int BITS_RED   = 5,
    parameter int BITS_GREEN = 6,
    parameter int BITS_BLUE  = 5
) (
    input  logic [23:0]                                pixel,
    input  logic                                       x0,
    input  logic                                       y0,
    output logic [BITS_RED+BITS_GREEN+BITS_BLUE-1:0]   rgb
);

    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;

`ifdef FB_DITHER_EN
    logic [1:0] t;
    logic [8:0] r_sum;
    logic [8:0] g_sum;
    logic [8:0] b_sum;

    // Red/blue get twice the threshold of green since they keep one fewer bit.
    always_comb begin
        t     = dither_t({y0, x0});
        r_sum = {1'b0, pixel[RGB888_R_LSB +: RGB888_CH_W]} + {6'd0, t, 1'b0};
        g_sum = {1'b0, pixel[RGB888_G_LSB +: RGB888_CH_W]} + {7'd0, t};
        b_sum = {1'b0, pixel[RGB888_B_LSB +: RGB888_CH_W]} + {6'd0, t, 1'b0};
        r8    = r_sum[8] ? 8'hFF : r_sum[7:0];
        g8    = g_sum[8] ? 8'hFF : g_sum[7:0];
        b8    = b_sum[8] ? 8'hFF : b_sum[7:0];
    end
`else
    assign r8 = pixel[RGB888_R_LSB +: RGB888_CH_W];
    assign g8 = pixel[RGB888_G_LSB +: RGB888_CH_W];
    assign b8 = pixel[RGB888_B_LSB +: RGB888_CH_W];
`endif

    assign rgb = {b8[7 -: BITS_BLUE], g8[7 -: BITS_GREEN], r8[7 -: BITS_RED]};

    // Truncated LSBs, and the position bits when dither is off, are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{r8, g8, b8, x0, y0};

endmodule

// File: rtl/fb_stream_writer.sv
// Framed RGB888 pixel stream -> row-major frame-buffer writes for the LED panel display block.
// Optional 2x2 ordered dither before truncation: define FB_DITHER_EN.
module fb_stream_writer
    import fb_pkg::*;
#(
    parameter int HEIGHT       = 64,
    parameter int WIDTH        = 64,
    parameter int CHAIN_LENGTH = 1,
    parameter int BITS_RED     = 5,
    parameter int BITS_GREEN   = 6,
    parameter int BITS_BLUE    = 5
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sof,
    input  logic [23:0] in_data,
    output logic        ctrl_en,
    output logic [3:0]  ctrl_wr,
    output logic [15:0] ctrl_addr,
    output logic [23:0] ctrl_wdat,
    output logic        frame_done,
    output logic        frame_err,
    output logic        frame_active
);

    localparam int LINE_W  = WIDTH * CHAIN_LENGTH;
    localparam int XW      = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int PIX_W   = BITS_RED + BITS_GREEN + BITS_BLUE;
    localparam logic [XW-1:0] X_LAST = XW'(LINE_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    fb_state_e        state_q, state_d;
    logic [XW-1:0]    x_q, x_d, wx;
    logic [YW-1:0]    y_q, y_d, wy;
    logic             ready_q;
    logic             accept;
    logic             wr_en, err, done;
    logic [PIX_W-1:0] rgb;

    logic             en_q, done_q, err_q;
    logic [15:0]      addr_q;
    logic [23:0]      wdat_q;

    assign accept = in_valid & ready_q;

    // wx/wy is the position this beat is written at; the next position advances from it,
    // so an sof restart and a normal beat share the same wrap/end-of-frame logic.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        wx      = x_q;
        wy      = y_q;
        wr_en   = 1'b0;
        err     = 1'b0;
        done    = 1'b0;
        if (accept) begin
            if (in_sof) begin
                wr_en = 1'b1;
                wx    = '0;
                wy    = '0;
                err   = (state_q == ACTIVE) && ((x_q != '0) || (y_q != '0));
            end else if (state_q == IDLE) begin
                err   = 1'b1;
            end else begin
                wr_en = 1'b1;
            end
            if (wr_en) begin
                if ((wx == X_LAST) && (wy == Y_LAST)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    state_d = ACTIVE;
                    if (wx == X_LAST) begin
                        x_d = '0;
                        y_d = wy + 1'b1;
                    end else begin
                        x_d = wx + 1'b1;
                        y_d = wy;
                    end
                end
            end
        end
    end

    rgb888_to_565 #(
        .BITS_RED   (BITS_RED),
        .BITS_GREEN (BITS_GREEN),
        .BITS_BLUE  (BITS_BLUE)
    ) u_conv (
        .pixel (in_data),
        .x0    (wx[0]),
        .y0    (wy[0]),
        .rgb   (rgb)
    );

    always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
        if (!ctrl_rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ready_q <= 1'b1;
        end
    end

    // Address and data hold their last value across bubbles.
    always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
        if (!ctrl_rst_n) begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= '0;
            wdat_q <= '0;
        end else begin
            en_q   <= wr_en;
            done_q <= done;
            err_q  <= err;
            if (wr_en) begin
                addr_q <= 16'({wy, wx});
                wdat_q <= 24'(rgb);
            end
        end
    end

    assign in_ready     = ready_q;
    assign ctrl_en      = en_q;
    assign ctrl_wr      = en_q ? WR_MASK_RGB : 4'b0000;
    assign ctrl_addr    = addr_q;
    assign ctrl_wdat    = wdat_q;
    assign frame_done   = done_q;
    assign frame_err    = err_q;
    assign frame_active = (state_q == ACTIVE);

endmodule

// File: tb/tb_fb_stream_writer.sv
// Directed + random stimulus for fb_stream_writer with a per-cycle expected-output queue.
module tb_fb_stream_writer;

    typedef struct packed {
        logic        en;
        logic [3:0]  wr;
        logic [15:0] addr;
        logic [23:0] wdat;
        logic        done;
        logic        err;
        logic        active;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [23:0] in_data;
    logic        ctrl_en;
    logic [3:0]  ctrl_wr;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;
    logic        frame_done;
    logic        frame_err;
    logic        frame_active;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    logic        m_active;
    int          m_x, m_y;
    logic [15:0] last_addr;
    logic [23:0] last_wdat;

    fb_stream_writer dut (
        .ctrl_clk     (clk),
        .ctrl_rst_n   (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sof       (in_sof),
        .in_data      (in_data),
        .ctrl_en      (ctrl_en),
        .ctrl_wr      (ctrl_wr),
        .ctrl_addr    (ctrl_addr),
        .ctrl_wdat    (ctrl_wdat),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .frame_active (frame_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] conv(input logic [23:0] d, input int x, input int y);
        int r, g, b, t;
        r = d[23:16];
        g = d[15:8];
        b = d[7:0];
        t = 0;
`ifdef FB_DITHER_EN
        if      (x % 2 == 1 && y % 2 == 0) t = 2;
        else if (x % 2 == 0 && y % 2 == 1) t = 3;
        else if (x % 2 == 1 && y % 2 == 1) t = 1;
        r = (r + 2 * t > 255) ? 255 : r + 2 * t;
        g = (g + t > 255) ? 255 : g + t;
        b = (b + 2 * t > 255) ? 255 : b + 2 * t;
`endif
        return {8'h00, 5'(b / 8), 6'(g / 4), 5'(r / 8)};
    endfunction

    task automatic model_reset();
        m_active  = 1'b0;
        m_x       = 0;
        m_y       = 0;
        last_addr = '0;
        last_wdat = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drives one cycle of input and queues the output expected one clock later.
    task automatic step(input logic v, input logic sof, input logic [23:0] d);
        exp_t e;
        int   wx, wy;
        logic w;
        @(negedge clk);
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        e = '0;
        w = 1'b0;
        wx = m_x;
        wy = m_y;
        if (v) begin
            if (sof) begin
                e.err = m_active && (m_x != 0 || m_y != 0);
                wx = 0;
                wy = 0;
                w = 1'b1;
            end else if (!m_active) begin
                e.err = 1'b1;
            end else begin
                w = 1'b1;
            end
            if (w) begin
                last_addr = 16'(wy * 64 + wx);
                last_wdat = conv(d, wx, wy);
                if (wx == 63 && wy == 63) begin
                    e.done   = 1'b1;
                    m_active = 1'b0;
                    m_x      = 0;
                    m_y      = 0;
                end else begin
                    m_active = 1'b1;
                    m_x      = (wx == 63) ? 0 : wx + 1;
                    m_y      = (wx == 63) ? wy + 1 : wy;
                end
            end
        end
        e.en     = w;
        e.wr     = w ? 4'b0111 : 4'b0000;
        e.addr   = last_addr;
        e.wdat   = last_wdat;
        e.active = m_active;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e, o;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat, frame_done, frame_err, frame_active};
            if (frame_done) done_cnt++;
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL scoreboard: observed %h expected %h", o, e);
            end
        end
    end

    initial begin
        int cnt;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        model_reset();

        #3;
        check("reset_ready", {31'd0, in_ready}, 32'd0);
        check("reset_outs", {ctrl_en, ctrl_wr, frame_done, frame_err, frame_active, 25'd0}, 32'd0);
        check("reset_addr_wdat", {8'd0, ctrl_wdat} | {16'd0, ctrl_addr}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Frame 1: continuous, directed first pixel.
        done_cnt = 0;
        step(1'b1, 1'b1, 24'hFF8040);
        @(posedge clk);
        #2;
        check("first_wdat", {8'd0, ctrl_wdat}, 32'h0000441F);
        check("first_wr", {28'd0, ctrl_wr}, 32'h7);
        check("first_addr", {16'd0, ctrl_addr}, 32'h0);
        for (int i = 1; i < 4096; i++) step(1'b1, 1'b0, 24'($urandom));
        @(posedge clk);
        #2;
        check("last_addr", {16'd0, ctrl_addr}, 32'h0FFF);
        check("last_done", {31'd0, frame_done}, 32'd1);
        step(1'b0, 1'b0, 24'd0);
        @(posedge clk);
        #2;
        check("active_after_done", {31'd0, frame_active}, 32'd0);
        check("done_once", done_cnt, 32'd1);

        // Frame 2: roughly half the cycles are bubbles.
        cnt = 0;
        while (cnt < 4096) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            step(v, v && cnt == 0, 24'($urandom));
            if (v) cnt++;
        end
        step(1'b0, 1'b0, 24'd0);
        step(1'b0, 1'b0, 24'd0);
        check("done_twice", done_cnt, 32'd2);

        // Beats without sof while idle are dropped.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'($urandom));

        // sof at pixel 100 restarts the frame.
        step(1'b1, 1'b1, 24'($urandom));
        for (int i = 1; i < 100; i++) step(1'b1, 1'b0, 24'($urandom));
        step(1'b1, 1'b1, 24'h123456);
        @(posedge clk);
        #2;
        check("restart_err", {31'd0, frame_err}, 32'd1);
        check("restart_addr", {16'd0, ctrl_addr}, 32'h0);
        step(1'b1, 1'b0, 24'($urandom));
        @(posedge clk);
        #2;
        check("restart_next_addr", {16'd0, ctrl_addr}, 32'h1);

        // Reset mid-frame at pixel 2000.
        while (m_y * 64 + m_x < 2000) step(1'b1, 1'b0, 24'($urandom));
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outs", {ctrl_en, ctrl_wr, frame_done, frame_err, frame_active, in_ready, 24'd0}, 32'd0);
        check("midreset_addr_wdat", {8'd0, ctrl_wdat} | {16'd0, ctrl_addr}, 32'd0);
        in_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'($urandom));

        // Dither positions (plain truncation expectations when dither is off).
        step(1'b1, 1'b1, 24'h000000);
        step(1'b1, 1'b0, 24'h050505);
        @(posedge clk);
        #2;
`ifdef FB_DITHER_EN
        check("dither_r5", {27'd0, ctrl_wdat[4:0]}, 32'd1);
`else
        check("trunc_r5", {27'd0, ctrl_wdat[4:0]}, 32'd0);
`endif
        for (int i = 2; i < 64; i++) step(1'b1, 1'b0, 24'($urandom));
        step(1'b1, 1'b0, 24'hFFFFFF);
        @(posedge clk);
        #2;
        check("saturate", {8'd0, ctrl_wdat}, 32'h0000FFFF);
        check("sat_addr", {16'd0, ctrl_addr}, 32'h0040);
        while (m_active) step(1'b1, 1'b0, 24'($urandom));
        step(1'b0, 1'b0, 24'd0);

        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 32'd0);
        check("done_total", done_cnt, 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
